// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/slave loopback block.
package spi_pkg;

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned CLK_DIV = 10;
    localparam int unsigned BCNT_W  = $clog2(DATA_W);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // Counter width for a counter spanning 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_slave.sv
// Loopback slave: samples mosi on sclk falling strobes while cs is low and
// presents each completed word on dout with a one-sclk-period done pulse.
import spi_pkg::*;

module spi_slave #(
    parameter int unsigned DATA_W = spi_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fall_en,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done
);

    localparam int unsigned BW = cnt_w(DATA_W);

    // Holds only the DATA_W-1 bits received so far; the final bit is taken
    // straight from mosi when the word is assembled into dout.
    logic [DATA_W-2:0] sreg;
    logic [BW-1:0]     bcnt;

    // Bit capture, word completion and done pulse timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            bcnt <= '0;
            dout <= '0;
            done <= 1'b0;
        end else if (fall_en) begin
            done <= 1'b0;
            if (!cs) begin
                if (bcnt == BW'(DATA_W - 1)) begin
                    dout <= {mosi, sreg};
                    done <= 1'b1;
                    bcnt <= '0;
                    sreg <= '0;
                end else begin
                    sreg <= {mosi, sreg[DATA_W-2:1]};
                    bcnt <= bcnt + 1'b1;
                end
            end else begin
                bcnt <= '0;
            end
        end
    end

endmodule

// File: rtl/spi.sv
// SPI master with free-running sclk divider, LSB-first transmit and an
// internal loopback slave that reassembles the transmitted word.
import spi_pkg::*;

module spi #(
    parameter int unsigned DATA_W  = spi_pkg::DATA_W,
    parameter int unsigned CLK_DIV = spi_pkg::CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              sclk,
    output logic              cs,
    output logic              mosi
);

    localparam int unsigned DIVW = cnt_w(CLK_DIV);
    localparam int unsigned BW   = cnt_w(DATA_W);

    logic [DIVW-1:0]   div_cnt;
    logic              div_hit;
    logic              rise_en;
    logic              fall_en;
    state_t            state;
    logic [DATA_W-1:0] sreg;
    logic [BW-1:0]     bcnt;

    // Strobes fire on the clk edge that toggles sclk, so logic acting on them
    // sees the same edge as the sclk transition.
    always_comb begin
        div_hit = (div_cnt == DIVW'(CLK_DIV - 1));
        rise_en = div_hit && !sclk;
        fall_en = div_hit && sclk;
    end

    // Free-running sclk divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (div_hit) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Master FSM: accepts start on a rising strobe and shifts din out LSB first.
    // The shift register holds the bits still to be sent after the one on mosi.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            bcnt  <= '0;
            cs    <= 1'b1;
            mosi  <= 1'b0;
        end else if (rise_en) begin
            case (state)
                IDLE: begin
                    cs   <= 1'b1;
                    mosi <= 1'b0;
                    if (start) begin
                        sreg  <= {1'b0, din[DATA_W-1:1]};
                        bcnt  <= '0;
                        cs    <= 1'b0;
                        mosi  <= din[0];
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (bcnt != BW'(DATA_W - 1)) begin
                        mosi <= sreg[0];
                        sreg <= sreg >> 1;
                        bcnt <= bcnt + 1'b1;
                    end else begin
                        cs    <= 1'b1;
                        mosi  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    cs    <= 1'b1;
                    mosi  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    spi_slave #(
        .DATA_W(DATA_W)
    ) u_slave (
        .clk    (clk),
        .rst    (rst),
        .fall_en(fall_en),
        .cs     (cs),
        .mosi   (mosi),
        .dout   (dout),
        .done   (done)
    );

endmodule

// File: tb/tb_spi.sv
// Scoreboard bench for the spi loopback block.
module tb_spi;

    localparam int unsigned W   = 12;
    localparam int unsigned DIV = 10;
    localparam int unsigned PER = 2 * DIV;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;
    logic         done, sclk, cs, mosi;

    spi #(.DATA_W(W), .CLK_DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .din  (din),
        .dout (dout),
        .done (done),
        .sclk (sclk),
        .cs   (cs),
        .mosi (mosi)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [W-1:0] dq[$];   // expected received words
    logic         bq[$];   // expected mosi bits, in wire order

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at t=%0t", nm, $time);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops expectations whenever the DUT presents a word, a bit, or
    // ends a done pulse / chip-select window.
    logic pd = 1'b0, ps = 1'b0, pc = 1'b1;
    int   dw = 0, cl = 0;
    initial forever begin
        @(negedge clk);
        if (done && !pd) begin
            if (dq.size() == 0) timeout("unexpected_done");
            else chk("dout", 32'(dout), 32'(dq.pop_front()));
        end
        if (done) dw++;
        if (!done && pd) begin
            chk("done_width", 32'(dw), 32'(PER));
            dw = 0;
        end
        if (sclk && !ps) begin
            if (!cs) begin
                if (bq.size() == 0) timeout("unexpected_bit");
                else chk("mosi", 32'(mosi), 32'(bq.pop_front()));
            end else begin
                chk("mosi_idle", 32'(mosi), 32'd0);
            end
        end
        if (!cs) cl++;
        if (cs && !pc) begin
            if (!rst) chk("cs_low_len", 32'(cl), 32'(W * PER));
            cl = 0;
        end
        pd = done;
        ps = sclk;
        pc = cs;
    end

    task automatic push_word(input logic [W-1:0] w, input bit expect_dout);
        for (int i = 0; i < int'(W); i++) bq.push_back(w[i]);
        if (expect_dout) dq.push_back(w);
    endtask

    task automatic wait_cs(input logic lvl, input string nm, output int t);
        bit seen = 0;
        t = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (cs === lvl) begin
                seen = 1;
                t = cyc;
            end
        end
        if (!seen) timeout(nm);
    endtask

    task automatic wait_done_fall(input string nm);
        bit hi = 0, lo = 0;
        for (int i = 0; i < 1000 && !hi; i++) begin
            @(negedge clk);
            if (done === 1'b1) hi = 1;
        end
        for (int i = 0; i < 1000 && hi && !lo; i++) begin
            @(negedge clk);
            if (done === 1'b0) lo = 1;
        end
        if (!lo) timeout(nm);
    endtask

    task automatic first_rise(input string nm);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!sclk && n < int'(4 * DIV));
        chk(nm, 32'(n), 32'(DIV));
    endtask

    task automatic xfer(input logic [W-1:0] w, input string nm);
        int t;
        din = w;
        push_word(w, 1'b1);
        start = 1'b1;
        wait_cs(1'b0, nm, t);
        start = 1'b0;
        wait_done_fall(nm);
    endtask

    initial begin
        int t1, t2, tp, tx;
        logic [W-1:0] w;

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        rst = 1'b0;
        first_rise("first_rise");

        // Single transfer and edge values
        xfer(12'hA5C, "xfer_a5c");
        xfer(12'h000, "xfer_000");
        xfer(12'hFFF, "xfer_fff");
        xfer(12'h001, "xfer_001");

        // Start held high across two acceptances
        w = 12'($urandom);
        din = w;
        push_word(w, 1'b1);
        push_word(w, 1'b1);
        start = 1'b1;
        wait_cs(1'b0, "held_acc1", t1);
        wait_cs(1'b1, "held_end1", tx);
        wait_cs(1'b0, "held_acc2", t2);
        start = 1'b0;
        chk("held_cadence", 32'(t2 - t1), 32'(13 * PER));
        wait_done_fall("held_done");

        // Back-to-back, start re-asserted as done falls
        tp = 0;
        for (int i = 0; i < 10; i++) begin
            w = 12'($urandom);
            din = w;
            push_word(w, 1'b1);
            start = 1'b1;
            wait_cs(1'b0, "b2b_acc", t1);
            start = 1'b0;
            if (i > 0) chk("b2b_cadence", 32'(t1 - tp), 32'(13 * PER));
            tp = t1;
            wait_done_fall("b2b_done");
        end

        // Reset partway through a word
        din = 12'h3C3;
        push_word(12'h3C3, 1'b0);
        start = 1'b1;
        wait_cs(1'b0, "abort_acc", t1);
        start = 1'b0;
        repeat (5 * PER + 3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_cs", 32'(cs), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_mosi", 32'(mosi), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dout", 32'(dout), 32'd0);
        bq.delete();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        first_rise("abort_first_rise");
        chk("abort_no_word", 32'(dout), 32'd0);
        xfer(12'h3C3, "xfer_3c3");

        repeat (2 * PER) @(negedge clk);
        chk("words_left", 32'(dq.size()), 32'd0);
        chk("bits_left", 32'(bq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete at t=%0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
